// File: rtl/byte_serial_add_ctrl_pkg.sv
// byte_serial_add_ctrl_pkg: shared states and constants for the byte-serial adder sequencer
package byte_serial_add_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int BYTE_W = 8;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/Full_ADDER8bit.sv
// Full_ADDER8bit: 8-bit ripple-carry adder slice
module Full_ADDER8bit (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       cin,
   output logic [7:0] z,
   output logic       cout
);
   logic [8:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign z[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign cout = c[8];
endmodule

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: wide add/sub run one byte per clock through a single 8-bit adder slice
module byte_serial_add_ctrl
   import byte_serial_add_ctrl_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int IDX_W  = $clog2(NBYTES),
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sub,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow,
   output logic         busy
);
   state_t state, state_nx;
   logic [IDX_W-1:0] idx;
   logic [W-1:0] a_r, b_r;
   logic sub_r, carry_r, cout, last;
   logic [BYTE_W-1:0] x, y, z;
   assign x    = a_r[idx*BYTE_W +: BYTE_W];
   assign y    = b_r[idx*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_r != OP_ADD}};
   assign last = idx == IDX_W'(NBYTES - 1);
   Full_ADDER8bit u_slice (.x(x), .y(y), .cin(carry_r), .z(z), .cout(cout));
   always_comb begin
      state_nx    = state == IDLE ? (start_valid ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : state == DONE ? (res_ready ? IDLE : DONE)
                  : IDLE;
      start_ready = state == IDLE;
      res_valid   = state == DONE;
      busy        = state == RUN || state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         sub_r     <= 1'b0;
         carry_r   <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            sub_r   <= sub;
            idx     <= '0;
            carry_r <= sub == OP_SUB;
         end
         if (state == RUN) begin
            result[idx*BYTE_W +: BYTE_W] <= z;
            carry_r <= cout;
            idx     <= last ? '0 : idx + IDX_W'(1);
            if (last) begin
               carry_out <= cout;
               overflow  <= (x[7] == y[7]) && (z[7] != x[7]);
            end
         end
      end
   end
endmodule
